// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the 5-stage Y86-64 pipeline.
//
// Purpose:
//   Derives the stall/bubble strobes for every pipeline register from the
//   load/use, mispredict and return hazards. A RUN/DRAIN/HALTED state machine
//   freezes the pipe once a bad status reaches W. Saturating counters record
//   hazard activity.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   D_icode .. W_stat   stage information used for hazard detection
//   F_stall .. W_stall  pipeline register control strobes (combinational)
//   set_cc_en           condition-code write enable for E
//   halted, final_stat  registered freeze flag and captured W status
//   cyc_cnt .. ret_cnt  saturating event counters (CNT_W bits)
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc_en,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic [2:0]       final_stat_q, final_stat_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

    logic lu, mp, ret, m_bad, w_bad, active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        logic [CNT_W-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return (en && (v != '1)) ? v + one : v;
    endfunction

    always_comb begin
        lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp     = (E_icode == IJXX) && !e_Cnd;
        ret    = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        m_bad  = (m_stat != SAOK);
        w_bad  = (W_stat != SAOK);
        active = (state_q != ST_HALTED);
    end

    // Reset overrides everything so NOPs flush the pipe while it is held.
    always_comb begin
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b1;
        E_bubble  = 1'b1;
        M_bubble  = 1'b1;
        W_stall   = 1'b0;
        set_cc_en = 1'b0;
        if (!reset) begin
            if (state_q == ST_HALTED) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end else begin
                F_stall   = lu | ret;
                D_stall   = lu;
                D_bubble  = mp | (ret & ~lu);
                E_bubble  = mp | lu;
                M_bubble  = m_bad | w_bad;
                W_stall   = w_bad;
                set_cc_en = (E_icode == IOPQ) & ~m_bad & ~w_bad;
            end
        end
    end

    // Counters advance on every edge taken from RUN/DRAIN, including the
    // edge that enters HALTED.
    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        final_stat_d = final_stat_q;
        if (active && w_bad) begin
            state_d      = ST_HALTED;
            halted_d     = 1'b1;
            final_stat_d = W_stat;
        end else if ((state_q == ST_RUN) && m_bad) begin
            state_d = ST_DRAIN;
        end
        cyc_cnt_d = sat_inc(cyc_cnt_q, active);
        lu_cnt_d  = sat_inc(lu_cnt_q, active & lu);
        mp_cnt_d  = sat_inc(mp_cnt_q, active & mp);
        ret_cnt_d = sat_inc(ret_cnt_q, active & ret & ~lu);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            halted_q     <= 1'b0;
            final_stat_q <= SAOK;
            cyc_cnt_q    <= '0;
            lu_cnt_q     <= '0;
            mp_cnt_q     <= '0;
            ret_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            final_stat_q <= final_stat_d;
            cyc_cnt_q    <= cyc_cnt_d;
            lu_cnt_q     <= lu_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

    assign halted     = halted_q;
    assign final_stat = final_stat_q;
    assign cyc_cnt    = cyc_cnt_q;
    assign lu_cnt     = lu_cnt_q;
    assign mp_cnt     = mp_cnt_q;
    assign ret_cnt    = ret_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// A second instance with 4-bit counters exercises saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset, rst4;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted;
    logic [2:0]  final_stat;
    logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc_en4, halted4;
    logic [2:0]  final_stat4;
    logic [3:0]  cyc_cnt4, lu_cnt4, mp_cnt4, ret_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc_en(set_cc_en), .halted(halted), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(rst4), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall4), .D_stall(D_stall4),
        .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
        .set_cc_en(set_cc_en4), .halted(halted4), .final_stat(final_stat4),
        .cyc_cnt(cyc_cnt4), .lu_cnt(lu_cnt4), .mp_cnt(mp_cnt4), .ret_cnt(ret_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc_en
    task automatic chk_strobes(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en},
            {25'd0, exp});
    endtask

    task automatic quiet();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
        M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        rst4  = 1'b1;
        #1;
        chk_strobes("reset_strobes", 7'b0011100);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_final_stat", {29'd0, final_stat}, 32'd1);
        chk("reset_cyc", cyc_cnt, 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk_strobes("quiet_strobes", 7'b0000000);
        step();
        chk("cyc_after_1", cyc_cnt, 32'd1);

        // load/use
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        chk_strobes("lu_strobes", 7'b1101000);
        step();
        chk("lu_cnt_1", lu_cnt, 32'd1);
        E_dstM = 4'hF; d_srcA = 4'hF;
        #1;
        chk_strobes("lu_rnone", 7'b0000000);
        step();
        chk("lu_cnt_still_1", lu_cnt, 32'd1);

        // mispredict
        quiet(); E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        chk_strobes("mp_strobes", 7'b0011000);
        step();
        chk("mp_cnt_1", mp_cnt, 32'd1);
        e_Cnd = 1'b1;
        #1;
        chk_strobes("jxx_taken", 7'b0000000);
        step();
        chk("mp_cnt_still_1", mp_cnt, 32'd1);

        // return in D, E, M
        quiet(); D_icode = 4'h9;
        #1; chk_strobes("ret_in_d", 7'b1010000); step();
        D_icode = 4'h1; E_icode = 4'h9;
        #1; chk_strobes("ret_in_e", 7'b1010000); step();
        E_icode = 4'h1; M_icode = 4'h9;
        #1; chk_strobes("ret_in_m", 7'b1010000); step();
        chk("ret_cnt_3", ret_cnt, 32'd3);

        // load/use coincident with return in D
        quiet(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h3; d_srcB = 4'h3;
        #1;
        chk_strobes("lu_ret", 7'b1101000);
        step();
        chk("ret_cnt_unchanged", ret_cnt, 32'd3);
        chk("lu_cnt_2", lu_cnt, 32'd2);

        // OPq in E enables CC
        quiet(); E_icode = 4'h6;
        #1;
        chk_strobes("opq_cc", 7'b0000001);
        step();
        chk("cyc_10", cyc_cnt, 32'd10);

        // bad status in M, then W
        m_stat = 3'd3;
        #1;
        chk_strobes("m_bad", 7'b0000100);
        step();
        chk("drain_not_halted", {31'd0, halted}, 32'd0);
        m_stat = 3'd1; W_stat = 3'd3;
        #1;
        chk_strobes("w_bad", 7'b0000110);
        step();
        chk("halted_set", {31'd0, halted}, 32'd1);
        chk("final_stat_sadr", {29'd0, final_stat}, 32'd3);
        chk("cyc_at_halt", cyc_cnt, 32'd12);

        // halted: inputs toggle, outputs frozen
        W_stat = 3'd1; E_icode = 4'h6;
        #1;
        chk_strobes("halted_strobes", 7'b1111110);
        step();
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; W_stat = 3'd4;
        step();
        E_icode = 4'h7; e_Cnd = 1'b0;
        step();
        chk("cyc_frozen", cyc_cnt, 32'd12);
        chk("lu_frozen", lu_cnt, 32'd2);
        chk("mp_frozen", mp_cnt, 32'd1);
        chk("final_stat_held", {29'd0, final_stat}, 32'd3);

        // reset mid-cycle while halted
        #2;
        reset = 1'b1;
        #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_lu", lu_cnt, 32'd0);
        chk_strobes("rst_strobes", 7'b0011100);
        step();
        quiet();
        reset = 1'b0;
        #1;
        chk_strobes("post_rst_quiet", 7'b0000000);
        step(); chk("cyc_1", cyc_cnt, 32'd1);
        step(); chk("cyc_2", cyc_cnt, 32'd2);
        step(); chk("cyc_3", cyc_cnt, 32'd3);

        // simultaneous bad M and W: direct halt
        m_stat = 3'd3; W_stat = 3'd4;
        step();
        chk("direct_halt", {31'd0, halted}, 32'd1);
        chk("direct_final_stat", {29'd0, final_stat}, 32'd4);
        quiet();
        step();
        chk("direct_cyc_frozen", cyc_cnt, 32'd4);

        // saturation on the 4-bit instance
        rst4 = 1'b0;
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        for (int i = 0; i < 14; i++) step();
        chk("lu4_14", {28'd0, lu_cnt4}, 32'd14);
        for (int i = 0; i < 6; i++) step();
        chk("lu4_sat", {28'd0, lu_cnt4}, 32'd15);
        chk("cyc4_sat", {28'd0, cyc_cnt4}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
